fetch_ctrl: RTL and testbench

Instruction-fetch sequencer for the 5-stage RISC-V pipeline. It owns the PC, issues one-outstanding-request fetches to the instruction memory and fills the IF/ID pipeline register. It honours ID stalls through a one-entry skid buffer and applies redirects: EX-stage branch/JALR resolution, plus an ID-stage early redirect for JAL computed from the UJ-type immediate. Downstream, the immediate generator and decoder consume `id_instr`/`id_pc`.

---
 rtl/fetch_ctrl.sv | 165 ++++++++++++++++
 tb/tb_fetch_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, keeps one fetch outstanding, and fills IF/ID
// through a one-entry skid buffer. EX redirects take priority over early JAL redirects from ID.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        id_stall,
  input  logic        ex_redirect,
  input  logic [31:0] ex_target,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        jal_redirect
);

  localparam logic [6:0]  OP_JAL = 7'b1101111;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic        [31:0] r_fetch_pc;
  logic        [31:0] r_out_pc;
  logic               r_id_valid;
  logic        [31:0] r_id_instr;
  logic        [31:0] r_id_pc;
  logic               r_skid_valid;
  logic        [31:0] r_skid_instr;
  logic        [31:0] r_skid_pc;

  logic               w_req;
  logic               w_grant;
  logic               w_consume;
  logic               w_jal;
  logic               w_flush;
  logic               w_deliver;
  logic               w_slot_free;
  logic               w_to_skid;
  logic signed [31:0] w_imm_uj;
  logic        [31:0] w_jal_target;
  logic        [31:0] w_ex_target;

  function automatic logic signed [31:0] imm_uj(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  assign w_grant     = w_req & imem_gnt;
  assign w_consume   = r_id_valid & ~id_stall;
  assign w_jal       = w_consume & (r_id_instr[6:0] == OP_JAL) & ~ex_redirect;
  assign w_flush     = ex_redirect | w_jal;
  // A response is only meaningful in WAIT; any flush that cycle discards it.
  assign w_deliver   = (r_state == S_WAIT) & imem_rvalid & ~w_flush;
  assign w_slot_free = ~r_id_valid | ~id_stall;
  assign w_to_skid   = w_deliver & (~w_slot_free | r_skid_valid);

  assign w_imm_uj     = imm_uj(r_id_instr);
  assign w_jal_target = (r_id_pc + $unsigned(w_imm_uj)) & ~32'h3;
  assign w_ex_target  = ex_target & ~32'h3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_REQ;
      S_REQ: begin
        if (w_grant) begin
          w_state_nxt = w_flush ? S_DROP : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          w_state_nxt = S_REQ;
        end else if (w_flush) begin
          w_state_nxt = S_DROP;
        end
      end
      S_DROP: begin
        if (imem_rvalid) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Requests are held back while the skid is occupied, capping buffering at two entries.
  always_comb begin
    w_req = (r_state == S_REQ) & ~r_skid_valid;
  end

  assign imem_req     = w_req;
  assign imem_addr    = r_fetch_pc;
  assign id_valid     = r_id_valid;
  assign id_instr     = r_id_instr;
  assign id_pc        = r_id_pc;
  assign jal_redirect = w_jal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc <= RESET_PC;
      r_out_pc   <= RESET_PC;
    end else begin
      if (w_grant) begin
        r_out_pc <= r_fetch_pc;
      end
      if (ex_redirect) begin
        r_fetch_pc <= w_ex_target;
      end else if (w_jal) begin
        r_fetch_pc <= w_jal_target;
      end else if (w_deliver) begin
        r_fetch_pc <= r_out_pc + 32'd4;
      end
    end
  end

  // The skid entry is older than any new response, so it refills IF/ID first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_id_valid   <= 1'b0;
      r_id_instr   <= NOP;
      r_id_pc      <= '0;
      r_skid_valid <= 1'b0;
    end else if (w_flush) begin
      r_id_valid   <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_slot_free) begin
      if (r_skid_valid) begin
        r_id_valid   <= 1'b1;
        r_id_instr   <= r_skid_instr;
        r_id_pc      <= r_skid_pc;
        r_skid_valid <= w_deliver;
      end else if (w_deliver) begin
        r_id_valid <= 1'b1;
        r_id_instr <= imem_rdata;
        r_id_pc    <= r_out_pc;
      end else begin
        r_id_valid <= 1'b0;
      end
    end else if (w_deliver) begin
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_to_skid) begin
      r_skid_instr <= imem_rdata;
      r_skid_pc    <= r_out_pc;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: program-order reference model of the instruction stream seen by ID,
// a latency-randomised instruction memory, and directed reset/stall/redirect/JAL scenarios.
module tb_fetch_ctrl;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [6:0]  OP_JAL   = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_stall;
  logic        ex_redirect;
  logic [31:0] ex_target;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        jal_redirect;

  fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_stall    (id_stall),
    .ex_redirect (ex_redirect),
    .ex_target   (ex_target),
    .id_valid    (id_valid),
    .id_instr    (id_instr),
    .id_pc       (id_pc),
    .jal_redirect(jal_redirect)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  logic [31:0] prog [logic [31:0]];
  logic        owed;
  logic [31:0] owed_addr;
  int          cd;
  logic [31:0] gq[$];
  bit          gnt_rand;
  int          lat_min;
  int          lat_max;
  logic [31:0] exp_pc;
  int          ncons;
  logic        jal_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (prog.exists(a)) return prog[a];
    return {a[26:2], 7'b0010011};
  endfunction

  function automatic logic [31:0] jal_off(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
  endfunction

  // One clock cycle: drive inputs just after a falling edge, check, then wait for the next one.
  task automatic tick(input logic stall, input logic redir, input logic [31:0] tgt);
    logic        owed_now;
    logic        is_jal;
    logic [31:0] w;
    id_stall    = stall;
    ex_redirect = redir;
    ex_target   = tgt;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    imem_gnt    = 1'b0;
    owed_now    = owed;
    if (!rst_n) begin
      owed = 1'b0;
    end else begin
      if (owed) begin
        if (cd == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(owed_addr);
          owed        = 1'b0;
        end else begin
          cd--;
        end
      end
      imem_gnt = gnt_rand ? ($urandom_range(0, 9) < 7) : 1'b1;
    end
    #1;
    jal_q = jal_redirect;
    if (rst_n) begin
      if (imem_req && imem_gnt) begin
        owed      = 1'b1;
        owed_addr = imem_addr;
        cd        = int'($urandom_range(lat_min, lat_max)) - 1;
        gq.push_back(imem_addr);
      end
      w      = mem_word(exp_pc);
      is_jal = (id_instr[6:0] == OP_JAL);
      check_eq("jal_redirect", 32'(jal_redirect), 32'(id_valid && !stall && is_jal && !redir));
      if (id_valid && !stall && !redir) begin
        check_eq("id_pc", id_pc, exp_pc);
        check_eq("id_instr", id_instr, w);
        ncons++;
        if (w[6:0] == OP_JAL) exp_pc = (exp_pc + jal_off(w)) & ~32'h3;
        else exp_pc = exp_pc + 32'd4;
      end
      if (redir) exp_pc = tgt & ~32'h3;
      check_eq("req_while_owed", 32'(imem_req && owed_now), 32'd0);
      if (imem_req) check_eq("addr_align", 32'(imem_addr[1:0]), 32'd0);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic wait_grant(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (gq.size() > 0) begin
        ok = 1'b1;
        break;
      end
      tick(1'b0, 1'b0, 32'h0);
    end
  endtask

  task automatic wait_id(input logic [31:0] pc, input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (id_valid && id_pc == pc) begin
        ok = 1'b1;
        break;
      end
      tick(1'b0, 1'b0, 32'h0);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req"},   32'(imem_req), 32'd0);
    check_eq({tag, "_addr"},  imem_addr, RESET_PC);
    check_eq({tag, "_valid"}, 32'(id_valid), 32'd0);
    check_eq({tag, "_instr"}, id_instr, 32'h0000_0013);
    check_eq({tag, "_pc"},    id_pc, 32'h0);
    check_eq({tag, "_jal"},   32'(jal_redirect), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic req_h[10];
    logic idv_h[10];
    int   g;
    int   n0;
    int   kk;
    bit   ok;
    logic [20:0] imm;

    rst_n = 1'b0; id_stall = 1'b0; ex_redirect = 1'b0; ex_target = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    owed = 1'b0; owed_addr = '0; cd = 0; gnt_rand = 1'b0; lat_min = 1; lat_max = 1;
    exp_pc = RESET_PC; ncons = 0; jal_q = 1'b0;
    prog[32'h20]  = 32'h010000EF;
    prog[32'h40]  = 32'hFFDFF06F;
    prog[32'h108] = 32'h010000EF;
    for (int unsigned a = 32'h400; a < 32'h800; a += 4) begin
      if ($urandom_range(0, 9) == 0) begin
        kk = int'($urandom_range(0, 128)) - 64;
        if (kk == 0) kk = 1;
        imm = 21'(kk * 4);
        prog[a] = enc_jal(imm, 5'($urandom));
      end
    end

    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");

    // Release reset with an always-granting, one-cycle memory.
    rst_n = 1'b1;
    g = -1;
    for (int k = 0; k < 10; k++) begin
      req_h[k] = imem_req;
      idv_h[k] = id_valid;
      if (g < 0 && imem_req) g = k;
      tick(1'b0, 1'b0, 32'h0);
    end
    check_eq("first_req_seen", 32'(g >= 0 && g < 8), 32'd1);
    if (g >= 0 && g < 8) begin
      check_eq("first_valid_t1", 32'(idv_h[g+1]), 32'd0);
      check_eq("first_valid_t2", 32'(idv_h[g+2]), 32'd1);
      check_eq("second_req_t2",  32'(req_h[g+2]), 32'd1);
    end
    check_eq("grant_cnt_ge3", 32'(gq.size() >= 3), 32'd1);
    if (gq.size() >= 3) begin
      check_eq("fetch0", gq[0], 32'h0);
      check_eq("fetch1", gq[1], 32'h4);
      check_eq("fetch2", gq[2], 32'h8);
    end

    // Hold the stall long enough for the skid to fill and requests to stop.
    repeat (6) tick(1'b1, 1'b0, 32'h0);
    check_eq("stall_req_off", 32'(imem_req), 32'd0);
    check_eq("stall_valid",   32'(id_valid), 32'd1);
    n0 = ncons;
    repeat (6) tick(1'b0, 1'b0, 32'h0);
    check_eq("stall_drain", 32'(ncons - n0 >= 3), 32'd1);

    // Forward JAL at 0x20 (+16) and backward JAL at 0x40 (-4).
    wait_id(32'h20, 200, ok);
    check_eq("jal1_reached", 32'(ok), 32'd1);
    tick(1'b0, 1'b0, 32'h0);
    check_eq("jal1_pulse", 32'(jal_q), 32'd1);
    gq.delete();
    wait_grant(20, ok);
    check_eq("jal1_grant_seen", 32'(ok), 32'd1);
    if (ok) check_eq("jal1_target", gq[0], 32'h30);

    wait_id(32'h40, 200, ok);
    check_eq("jal2_reached", 32'(ok), 32'd1);
    tick(1'b0, 1'b0, 32'h0);
    check_eq("jal2_pulse", 32'(jal_q), 32'd1);
    gq.delete();
    wait_grant(20, ok);
    check_eq("jal2_grant_seen", 32'(ok), 32'd1);
    if (ok) check_eq("jal2_target", gq[0], 32'h3C);

    // EX redirect while a three-cycle fetch is outstanding.
    lat_min = 3; lat_max = 3;
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (owed && cd == 2) begin
        ok = 1'b1;
        break;
      end
      tick(1'b0, 1'b0, 32'h0);
    end
    check_eq("wait_state_reached", 32'(ok), 32'd1);
    tick(1'b0, 1'b1, 32'h103);
    check_eq("redir_flush_valid", 32'(id_valid), 32'd0);
    gq.delete();
    wait_grant(20, ok);
    check_eq("redir_grant_seen", 32'(ok), 32'd1);
    if (ok) check_eq("redir_target", gq[0], 32'h100);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (id_valid) begin
        ok = 1'b1;
        break;
      end
      tick(1'b0, 1'b0, 32'h0);
    end
    check_eq("redir_valid_seen", 32'(ok), 32'd1);
    if (ok) check_eq("redir_first_pc", id_pc, 32'h100);

    // EX redirect coincident with a JAL in ID.
    lat_min = 1; lat_max = 1;
    wait_id(32'h108, 100, ok);
    check_eq("jal3_reached", 32'(ok), 32'd1);
    tick(1'b0, 1'b1, 32'h200);
    check_eq("jal3_suppressed", 32'(jal_q), 32'd0);
    gq.delete();
    wait_grant(20, ok);
    check_eq("jal3_grant_seen", 32'(ok), 32'd1);
    if (ok) check_eq("jal3_target", gq[0], 32'h200);

    // Asynchronous reset with the skid full.
    repeat (6) tick(1'b1, 1'b0, 32'h0);
    check_eq("pre_reset_req_off", 32'(imem_req), 32'd0);
    #2;
    rst_n = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    #1;
    repeat (2) tick(1'b0, 1'b0, 32'h0);
    rst_n = 1'b1;
    exp_pc = RESET_PC;
    gq.delete();
    wait_grant(20, ok);
    check_eq("restart_grant_seen", 32'(ok), 32'd1);
    if (ok) check_eq("restart_addr", gq[0], RESET_PC);
    wait_id(RESET_PC, 20, ok);
    check_eq("restart_first_id", 32'(ok), 32'd1);

    // Randomised traffic in the JAL-rich region.
    gnt_rand = 1'b1; lat_min = 1; lat_max = 3;
    tick(1'b0, 1'b1, 32'h400);
    n0 = ncons;
    for (int k = 0; k < 3000; k++) begin
      tick($urandom_range(0, 9) < 3, $urandom_range(0, 99) < 3,
           32'h400 + ($urandom_range(0, 255) * 4) + $urandom_range(0, 3));
    end
    check_eq("random_progress", 32'(ncons - n0 > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
